fifo_rd_sched: RTL and testbench

- Read-side controller for the dual-clock FIFO. Shares the single FIFO read port between NREQ consumers using round-robin arbitration.
- Grants a consumer a fixed-length burst only when the whole burst is already in the FIFO, then drives one read per cycle.
- Sits in the rclk domain. Consumes the two-flop-synchronised Gray write pointer and produces the Gray read pointer (rptr), the read address and the empty flag.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_rd_sched_rr_arbiter.sv | 38 +++
 rtl/fifo_rd_sched.sv | 129 ++++++++++++
 tb/tb_fifo_rd_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared types and helpers for the dual-clock FIFO controllers.
//   state_t   : burst scheduler FSM states
//   calc_blw  : width of a burst-length field able to hold MAXBURST
//   bin2gray  : binary -> Gray (zero-extended to 32 bits, slice result)
//   gray2bin  : Gray -> binary (zero-extended to 32 bits, slice result)
package fifo_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic int calc_blw(input int maxburst);
        return $clog2(maxburst) + 1;
    endfunction

    // Upper zero bits stay zero in both conversions, so any width up to 32
    // can be handled by zero-extending the input and slicing the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker: returns the first eligible index at or
// after rr_ptr, wrapping around.
//   eligible : per-requester eligibility
//   rr_ptr   : index with highest priority this round
//   pick     : one-hot winner (zero when nothing eligible)
//   pick_idx : binary index of the winner
//   valid    : a winner exists
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PTRW-1:0] rr_ptr,
    output logic [NREQ-1:0] pick,
    output logic [PTRW-1:0] pick_idx,
    output logic            valid
);

    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // rr_ptr is always < NREQ, so one subtraction wraps correctly
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && eligible[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = PTRW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched
// Read-side controller of the dual-clock FIFO. Shares the read port between
// NREQ consumers; a consumer is granted a fixed-length burst only when the
// whole burst is already present, then one word is read per cycle.
//   rclk, rrst  : read clock, synchronous active-high reset
//   rq2_wptr    : synchronised Gray write pointer
//   req         : per-consumer burst request (level)
//   burst_len   : packed per-consumer burst lengths, field i = [i*BLW +: BLW]
//   grant       : one-hot owner of the running burst, zero when idle
//   rinc        : read strobe, data at raddr valid this cycle
//   raddr       : FIFO memory read address
//   rptr        : Gray read pointer to the r2w synchroniser
//   rempty      : registered empty flag
//   rcount      : registered words-available count
//   burst_last  : final beat of the running burst
module fifo_rd_sched
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4,
    parameter int BLW      = calc_blw(MAXBURST)
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*BLW-1:0] burst_len,
    output logic [NREQ-1:0]     grant,
    output logic                rinc,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                burst_last
);

    localparam int PW   = ADDRSIZE + 1;
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [PW-1:0]   rbin;
    logic [PW-1:0]   rbin_next;
    logic [PW-1:0]   wbin;
    logic [PW-1:0]   avail;
    logic [BLW-1:0]  beats;
    logic [PTRW-1:0] rr_ptr;

    logic [BLW-1:0]  len [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic [PTRW-1:0] pick_idx;
    logic            pick_valid;

    // The wrap bit makes the modulo subtraction give 0..depth inclusive.
    assign wbin      = PW'(gray2bin(32'(rq2_wptr)));
    assign avail     = wbin - rbin;
    assign rbin_next = (state == BURST) ? rbin + 1'b1 : rbin;

    assign rinc       = (state == BURST);
    assign burst_last = (state == BURST) && (beats == BLW'(1));
    assign raddr      = rbin[ADDRSIZE-1:0];

    // Clamp each requested length and decide who could run a burst now.
    always_comb begin
        logic [BLW-1:0] field;
        field    = '0;
        len      = '{default: '0};
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            field       = burst_len[i*BLW +: BLW];
            len[i]      = (32'(field) > 32'(MAXBURST)) ? BLW'(MAXBURST) : field;
            eligible[i] = req[i] && (field != '0) && (32'(avail) >= 32'(len[i]));
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Burst FSM plus pointer/flag registers. Arbitration only happens in
    // IDLE, which guarantees at least one idle cycle between bursts.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state  <= IDLE;
            rbin   <= '0;
            rptr   <= '0;
            grant  <= '0;
            beats  <= '0;
            rr_ptr <= '0;
            rempty <= 1'b1;
            rcount <= '0;
        end else begin
            rbin   <= rbin_next;
            rptr   <= PW'(bin2gray(32'(rbin_next)));
            rempty <= (PW'(bin2gray(32'(rbin_next))) == rq2_wptr);
            rcount <= avail;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= BURST;
                        grant  <= pick;
                        beats  <= len[pick_idx];
                        rr_ptr <= (pick_idx == PTRW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                BURST: begin
                    beats <= beats - 1'b1;
                    if (beats == BLW'(1)) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched
// Directed bench for fifo_rd_sched with ADDRSIZE=4, NREQ=4, MAXBURST=4
// (BLW=3). Inputs change 1 ns after the rising edge and outputs are sampled
// at that same point, well away from the next active edge.
module tb_fifo_rd_sched;

    localparam int ADDRSIZE = 4;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 4;
    localparam int BLW      = 3;

    logic                rclk;
    logic                rrst;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [NREQ-1:0]     req;
    logic [NREQ*BLW-1:0] burst_len;
    logic [NREQ-1:0]     grant;
    logic                rinc;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic [ADDRSIZE:0]   rcount;
    logic                burst_last;

    int checks   = 0;
    int failures = 0;

    fifo_rd_sched #(
        .ADDRSIZE (ADDRSIZE),
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST),
        .BLW      (BLW)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rq2_wptr   (rq2_wptr),
        .req        (req),
        .burst_len  (burst_len),
        .grant      (grant),
        .rinc       (rinc),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .rcount     (rcount),
        .burst_last (burst_last)
    );

    // 10 ns read clock
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic set_len(input int idx, input int val);
        burst_len[idx*BLW +: BLW] = 3'(val);
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        tick();
        tick();
        rrst = 1'b0;
    endtask

    // Moves the read pointer forward with a single-consumer burst.
    task automatic do_burst(input int who, input int len, input int wbin);
        rq2_wptr = gray(wbin);
        req      = 4'(1 << who);
        set_len(who, len);
        tick();
        checks++;
        if (grant !== 4'(1 << who)) begin
            failures++;
            $display("[TB] FAIL prep_grant got=%b exp=%b", grant, 4'(1 << who));
        end
        req = '0;
        repeat (len) tick();
    endtask

    task automatic test_reset();
        rrst      = 1'b1;
        rq2_wptr  = '0;
        req       = 4'b1111;
        burst_len = {3'd1, 3'd1, 3'd1, 3'd1};
        tick();
        tick();
        checks++;
        if ({grant, rinc, rempty, rcount, rptr} !== {4'b0, 1'b0, 1'b1, 5'd0, 5'd0}) begin
            failures++;
            $display("[TB] FAIL reset_state got grant=%b rinc=%b rempty=%b rcount=%0d rptr=%b exp 0000 0 1 0 00000",
                     grant, rinc, rempty, rcount, rptr);
        end
        rrst = 1'b0;
        req  = '0;
    endtask

    task automatic test_single_burst();
        rq2_wptr = gray(3);
        req      = 4'b0100;
        set_len(2, 3);
        tick();
        checks++;
        if (grant !== 4'b0100 || rempty !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_grant got grant=%b rempty=%b exp 0100 0", grant, rempty);
        end
        req = '0;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) tick();
            checks++;
            if ({rinc, raddr, burst_last} !== {1'b1, 4'(b), (b == 2)}) begin
                failures++;
                $display("[TB] FAIL single_beat%0d got rinc=%b raddr=%0d last=%b exp 1 %0d %b",
                         b, rinc, raddr, burst_last, b, (b == 2));
            end
        end
        tick();
        checks++;
        if ({grant, rinc, rptr, rempty} !== {4'b0, 1'b0, 5'b00010, 1'b1}) begin
            failures++;
            $display("[TB] FAIL single_end got grant=%b rinc=%b rptr=%b rempty=%b exp 0000 0 00010 1",
                     grant, rinc, rptr, rempty);
        end
        tick();
        checks++;
        if (rcount !== 5'd0) begin
            failures++;
            $display("[TB] FAIL single_rcount got=%0d exp=0", rcount);
        end
    endtask

    // rbin=3, rr pointer=3 on entry.
    task automatic test_insufficient();
        rq2_wptr = gray(5);
        req      = 4'b0011;
        set_len(0, 4);
        set_len(1, 2);
        tick();
        checks++;
        if (grant !== 4'b0010 || raddr !== 4'd3) begin
            failures++;
            $display("[TB] FAIL insuf_grant got grant=%b raddr=%0d exp 0010 3", grant, raddr);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (raddr !== 4'd4 || burst_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL insuf_last got raddr=%0d last=%b exp 4 1", raddr, burst_last);
        end
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000 || rinc !== 1'b0) begin
            failures++;
            $display("[TB] FAIL insuf_wait got grant=%b rinc=%b exp 0000 0", grant, rinc);
        end
        rq2_wptr = gray(9);
        tick();
        checks++;
        if (grant !== 4'b0001 || raddr !== 4'd5) begin
            failures++;
            $display("[TB] FAIL insuf_late_grant got grant=%b raddr=%0d exp 0001 5", grant, raddr);
        end
        req = '0;
        tick();
        tick();
        tick();
        checks++;
        if (raddr !== 4'd8 || burst_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL insuf_late_last got raddr=%0d last=%b exp 8 1", raddr, burst_last);
        end
        tick();
    endtask

    // Zero length is skipped, oversized length clamps, full depth is valid.
    task automatic test_len_edge();
        rq2_wptr = gray(16);
        req      = 4'b0000;
        do_reset();
        req = 4'b0011;
        set_len(0, 0);
        set_len(1, 7);
        tick();
        checks++;
        if ({grant, rcount, rempty} !== {4'b0010, 5'd16, 1'b0}) begin
            failures++;
            $display("[TB] FAIL len_grant got grant=%b rcount=%0d rempty=%b exp 0010 16 0",
                     grant, rcount, rempty);
        end
        req = '0;
        tick();
        tick();
        tick();
        checks++;
        if (raddr !== 4'd3 || burst_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL len_clamp got raddr=%0d last=%b exp 3 1", raddr, burst_last);
        end
        tick();
        checks++;
        if (rinc !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len_end got rinc=%b exp 0", rinc);
        end
    endtask

    task automatic test_fairness();
        rq2_wptr  = gray(16);
        req       = 4'b1111;
        burst_len = {3'd1, 3'd1, 3'd1, 3'd1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({grant, rinc, burst_last} !== {4'(1 << (k % 4)), 1'b1, 1'b1}) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d got grant=%b rinc=%b last=%b exp %b 1 1",
                         k, grant, rinc, burst_last, 4'(1 << (k % 4)));
            end
            tick();
            checks++;
            if (grant !== 4'b0000 || rinc !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rr_idle%0d got grant=%b rinc=%b exp 0000 0", k, grant, rinc);
            end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        int exp_addr [4];
        exp_addr = '{14, 15, 0, 1};
        rq2_wptr = '0;
        req      = '0;
        do_reset();
        for (int k = 1; k <= 7; k++) do_burst(0, 4, 4 * k);
        do_burst(0, 2, 30);
        rq2_wptr = gray(2);
        req      = 4'b0001;
        set_len(0, 4);
        for (int b = 0; b < 4; b++) begin
            tick();
            req = '0;
            checks++;
            if ({rinc, raddr} !== {1'b1, 4'(exp_addr[b])}) begin
                failures++;
                $display("[TB] FAIL wrap_beat%0d got rinc=%b raddr=%0d exp 1 %0d",
                         b, rinc, raddr, exp_addr[b]);
            end
        end
        tick();
        checks++;
        if ({rinc, raddr, rptr, rempty} !== {1'b0, 4'd2, 5'b00011, 1'b1}) begin
            failures++;
            $display("[TB] FAIL wrap_end got rinc=%b raddr=%0d rptr=%b rempty=%b exp 0 2 00011 1",
                     rinc, raddr, rptr, rempty);
        end
    endtask

    // rbin=2, rr pointer=1 on entry.
    task automatic test_reset_mid_burst();
        rq2_wptr = gray(6);
        req      = 4'b0010;
        set_len(1, 4);
        tick();
        checks++;
        if (grant !== 4'b0010 || raddr !== 4'd2) begin
            failures++;
            $display("[TB] FAIL midrst_grant got grant=%b raddr=%0d exp 0010 2", grant, raddr);
        end
        tick();
        rrst = 1'b1;
        tick();
        checks++;
        if ({grant, rinc, raddr, rptr, rempty} !== {4'b0, 1'b0, 4'd0, 5'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midrst_abort got grant=%b rinc=%b raddr=%0d rptr=%b rempty=%b exp 0000 0 0 00000 1",
                     grant, rinc, raddr, rptr, rempty);
        end
        rrst = 1'b0;
        req  = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rinc !== 1'b0 || grant !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL midrst_quiet%0d got rinc=%b grant=%b exp 0 0000", c, rinc, grant);
            end
        end
    endtask

    initial begin
        rrst      = 1'b1;
        rq2_wptr  = '0;
        req       = '0;
        burst_len = '0;
        test_reset();
        test_single_burst();
        test_insufficient();
        test_len_edge();
        test_fairness();
        test_wrap();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
